// File: rtl/expression_root_finder.sv
// ============================================================================
// Module   : expression_root_finder
// Brief    : Finds the smallest 8-bit signed X with A*X^2 + B*X + C == Y by
//            a multiplier-free finite-difference sweep over X = -128..127.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expression_root_finder (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] A,
    input  logic signed [15:0] B,
    input  logic signed [15:0] C,
    input  logic signed [15:0] Y,
    output logic signed [7:0]  X,
    output logic               found,
    output logic               busy,
    output logic               completed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [7:0] C_X_FIRST = 8'sh80;
    localparam logic signed [7:0] C_X_LAST  = 8'sh7F;

    state_t             state_q, state_d;
    logic signed [15:0] a_q, a_d;
    logic signed [15:0] b_q, b_d;
    logic signed [15:0] c_q, c_d;
    logic signed [15:0] y_q, y_d;
    logic signed [33:0] p_q, p_d;
    logic signed [33:0] d_q, d_d;
    logic signed [7:0]  x_q, x_d;
    logic signed [7:0]  root_q, root_d;
    logic               found_q, found_d;

    // Sign-extended operands at the internal 34-bit width; the comparison is
    // done at full width so a 16-bit alias of P can never match.
    logic signed [33:0] w_a_ext;
    logic signed [33:0] w_b_ext;
    logic signed [33:0] w_c_ext;
    logic signed [33:0] w_y_ext;
    logic               w_match;

    assign w_a_ext = {{18{a_q[15]}}, a_q};
    assign w_b_ext = {{18{b_q[15]}}, b_q};
    assign w_c_ext = {{18{c_q[15]}}, c_q};
    assign w_y_ext = {{18{y_q[15]}}, y_q};
    assign w_match = (p_q == w_y_ext);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
            d_q     <= '0;
            x_q     <= '0;
            root_q  <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            y_q     <= y_d;
            p_q     <= p_d;
            d_q     <= d_d;
            x_q     <= x_d;
            root_q  <= root_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        y_d     = y_q;
        p_d     = p_q;
        d_d     = d_q;
        x_d     = x_q;
        root_d  = root_q;
        found_d = found_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = C;
                    y_d     = Y;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                // P(-128) and the first forward difference P(-127) - P(-128)
                x_d     = C_X_FIRST;
                p_d     = (w_a_ext <<< 14) - (w_b_ext <<< 7) + w_c_ext;
                d_d     = (w_a_ext - (w_a_ext <<< 8)) + w_b_ext;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (w_match) begin
                    root_d  = x_q;
                    found_d = 1'b1;
                    state_d = S_DONE;
                end else if (x_q == C_X_LAST) begin
                    root_d  = '0;
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    p_d = p_q + d_q;
                    d_d = d_q + (w_a_ext <<< 1);
                    x_d = x_q + 8'sd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign X         = root_q;
    assign found     = found_q;
    assign busy      = (state_q == S_INIT) || (state_q == S_SCAN);
    assign completed = (state_q == S_DONE);

endmodule

`default_nettype wire
